// File: rtl/pixel_write_fifo.sv
// Pixel write queue between the ray marcher and the frame-buffer BRAM port.
// Optional dropped-pixel counter: define PIXEL_WRITE_FIFO_DROP_COUNT_EN.
`ifndef H_BITS
`define H_BITS 8
`endif
`ifndef V_BITS
`define V_BITS 8
`endif

module pixel_write_fifo #(
    parameter int H_BITS = `H_BITS,
    parameter int V_BITS = `V_BITS,
    parameter int DEPTH  = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [H_BITS-1:0]        hcount_in,
    input  logic [V_BITS-1:0]        vcount_in,
    input  logic [3:0]               color_in,
    input  logic                     valid_in,
    input  logic                     new_frame_in,
    input  logic                     write_ready_in,
    output logic                     write_enable_out,
    output logic [H_BITS+V_BITS-1:0] write_addr_out,
    output logic [3:0]               write_data_out,
    output logic                     swap_buffers_out,
    output logic                     ready_out,
    output logic                     overflow_out,
    output logic [15:0]              drop_count_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int A_BITS = H_BITS + V_BITS;
    localparam logic [AW:0] OCC_MAX = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [A_BITS-1:0] addr;
        logic [3:0]        color;
        logic              pix;
        logic              mark;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WRITE, SWAP} state_t;

    entry_t            r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    state_t            r_state;
    state_t            w_state_nx;
    logic              r_pend_mark;
    logic              w_pend_mark_nx;
    logic              r_we;
    logic              w_we_nx;
    logic [A_BITS-1:0] r_addr;
    logic [A_BITS-1:0] w_addr_nx;
    logic [3:0]        r_data;
    logic [3:0]        w_data_nx;
    logic              r_swap;
    logic              w_swap_nx;
    logic              r_overflow;

    entry_t            w_in_entry;
    entry_t            w_head;
    logic [AW:0]       w_occ;
    logic              w_push_req;
    logic              w_push_ok;
    logic              w_push;
    logic              w_drop;
    logic              w_avail;
    logic              w_take;
    logic              w_pop;

    // The entry being written still holds its slot until the BRAM takes it.
    assign w_occ = r_count + (AW+1)'(r_state == WRITE);

    assign w_in_entry.addr  = {vcount_in, hcount_in};
    assign w_in_entry.color = color_in;
    assign w_in_entry.pix   = valid_in;
    assign w_in_entry.mark  = new_frame_in;

    assign w_push_req = valid_in | new_frame_in;
    assign w_push_ok  = new_frame_in ? (w_occ < OCC_MAX)
                                     : (w_occ < OCC_MAX - 1'b1);
    assign w_push     = w_push_req & w_push_ok;
    assign w_drop     = w_push_req & ~w_push_ok;

    // Empty queue: the incoming entry bypasses storage for 1-cycle latency.
    assign w_head  = (r_count != '0) ? r_mem[r_rd_ptr] : w_in_entry;
    assign w_avail = (r_count != '0) | w_push;

    always_comb begin
        w_state_nx     = r_state;
        w_pend_mark_nx = r_pend_mark;
        w_we_nx        = r_we;
        w_addr_nx      = r_addr;
        w_data_nx      = r_data;
        w_swap_nx      = 1'b0;
        w_take         = 1'b0;
        w_pop          = 1'b0;
        unique case (r_state)
            IDLE:  w_take = 1'b1;
            WRITE: begin
                if (write_ready_in) begin
                    if (r_pend_mark) begin
                        w_state_nx     = SWAP;
                        w_we_nx        = 1'b0;
                        w_swap_nx      = 1'b1;
                        w_pend_mark_nx = 1'b0;
                    end else begin
                        w_take = 1'b1;
                    end
                end
            end
            SWAP:  w_take = 1'b1;
            default: ;
        endcase
        if (w_take) begin
            if (w_avail) begin
                w_pop = 1'b1;
                if (w_head.pix) begin
                    w_state_nx     = WRITE;
                    w_we_nx        = 1'b1;
                    w_addr_nx      = w_head.addr;
                    w_data_nx      = w_head.color;
                    w_pend_mark_nx = w_head.mark;
                end else begin
                    w_state_nx = SWAP;
                    w_we_nx    = 1'b0;
                    w_swap_nx  = 1'b1;
                end
            end else begin
                w_state_nx = IDLE;
                w_we_nx    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wr_ptr] <= w_in_entry;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= IDLE;
            r_pend_mark <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_swap      <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pend_mark <= w_pend_mark_nx;
            r_we        <= w_we_nx;
            r_addr      <= w_addr_nx;
            r_data      <= w_data_nx;
            r_swap      <= w_swap_nx;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end

`ifdef PIXEL_WRITE_FIFO_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_drop_count <= '0;
        end else if (w_drop && valid_in && r_drop_count != 16'hFFFF) begin
            r_drop_count <= r_drop_count + 1'b1;
        end
    end

    assign drop_count_out = r_drop_count;
`else
    assign drop_count_out = '0;
`endif

    assign write_enable_out = r_we;
    assign write_addr_out   = r_addr;
    assign write_data_out   = r_data;
    assign swap_buffers_out = r_swap;
    assign overflow_out     = r_overflow;
    assign ready_out        = (w_occ < OCC_MAX - 1'b1);

endmodule

// File: tb/tb_pixel_write_fifo.sv
// Scoreboard bench for pixel_write_fifo: randomized pushes against a queue
// model of pending writes and swaps, plus directed boundary scenarios.
module tb_pixel_write_fifo;
    localparam int HB = 8;
    localparam int VB = 8;
    localparam int DEPTH = 16;
`ifdef PIXEL_WRITE_FIFO_DROP_COUNT_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [HB-1:0] hcount_in = '0;
    logic [VB-1:0] vcount_in = '0;
    logic [3:0] color_in = '0;
    logic valid_in = 1'b0;
    logic new_frame_in = 1'b0;
    logic write_ready_in = 1'b0;
    logic write_enable_out;
    logic [HB+VB-1:0] write_addr_out;
    logic [3:0] write_data_out;
    logic swap_buffers_out;
    logic ready_out;
    logic overflow_out;
    logic [15:0] drop_count_out;

    pixel_write_fifo #(.H_BITS(HB), .V_BITS(VB), .DEPTH(DEPTH)) dut (
        .clk_in(clk),
        .rst_n_in(rst_n),
        .hcount_in(hcount_in),
        .vcount_in(vcount_in),
        .color_in(color_in),
        .valid_in(valid_in),
        .new_frame_in(new_frame_in),
        .write_ready_in(write_ready_in),
        .write_enable_out(write_enable_out),
        .write_addr_out(write_addr_out),
        .write_data_out(write_data_out),
        .swap_buffers_out(swap_buffers_out),
        .ready_out(ready_out),
        .overflow_out(overflow_out),
        .drop_count_out(drop_count_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit swap;
        bit lone;
        logic [15:0] addr;
        logic [3:0] data;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int acc = 0;
    int ret = 0;
    int hs_pend = 0;
    int n_writes = 0;
    int n_swaps = 0;
    bit exp_ovf = 1'b0;
    logic [15:0] exp_drop = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write/swap the DUT presents must match the queue head.
    always @(negedge clk) begin
        ret += hs_pend;
        hs_pend = 0;
        if (rst_n) begin
            if (write_enable_out && swap_buffers_out) begin
                chk("we_and_swap", 1, 0);
            end else if (write_enable_out) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].swap) begin
                    failures++;
                    $display("FAIL unexpected_write: got addr %0d expected none",
                             write_addr_out);
                end else if (write_addr_out !== exp_q[0].addr ||
                             write_data_out !== exp_q[0].data) begin
                    failures++;
                    $display("FAIL write: got %0d/%0d expected %0d/%0d",
                             write_addr_out, write_data_out,
                             exp_q[0].addr, exp_q[0].data);
                end
                if (write_ready_in) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    hs_pend = 1;
                    n_writes++;
                end
            end else if (swap_buffers_out) begin
                checks++;
                n_swaps++;
                if (exp_q.size() == 0 || !exp_q[0].swap) begin
                    failures++;
                    $display("FAIL swap: got pulse expected %0d pending writes",
                             exp_q.size());
                end else begin
                    if (exp_q[0].lone) ret++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input bit v, input bit nf, input bit wr,
                       input int h, input int vv, input int c);
        int occ;
        bit ok;
        exp_t e;
        @(posedge clk);
        #1;
        valid_in = v;
        new_frame_in = nf;
        write_ready_in = wr;
        hcount_in = HB'(h);
        vcount_in = VB'(vv);
        color_in = 4'(c);
        @(negedge clk);
        #1;
        chk("overflow", overflow_out, exp_ovf);
        chk("drop_count", drop_count_out, exp_drop);
        occ = acc - ret;
        chk("ready", ready_out, occ < DEPTH - 1);
        if (v || nf) begin
            ok = nf ? (occ < DEPTH) : (occ < DEPTH - 1);
            if (ok) begin
                acc++;
                if (v) begin
                    e.swap = 0;
                    e.lone = 0;
                    e.addr = 16'(vv * (1 << HB) + h);
                    e.data = 4'(c);
                    exp_q.push_back(e);
                end
                if (nf) begin
                    e.swap = 1;
                    e.lone = !v;
                    e.addr = '0;
                    e.data = '0;
                    exp_q.push_back(e);
                end
            end else begin
                exp_ovf = 1'b1;
                if (v && DC_EN && exp_drop != 16'hFFFF) exp_drop++;
            end
        end
    endtask

    task automatic drain();
        int budget = 300;
        while (exp_q.size() != 0 && budget > 0) begin
            cyc(0, 0, 1, 0, 0, 0);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     exp_q.size());
        end
        repeat (3) cyc(0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w0;
        int s0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", write_enable_out, 0);
        chk("rst_addr", write_addr_out, 0);
        chk("rst_data", write_data_out, 0);
        chk("rst_swap", swap_buffers_out, 0);
        chk("rst_ovf", overflow_out, 0);
        chk("rst_drop", drop_count_out, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_ready", ready_out, 1);

        cyc(1, 0, 1, 3, 2, 5);
        cyc(0, 0, 1, 0, 0, 0);
        chk("pass_we", write_enable_out, 1);
        chk("pass_addr", write_addr_out, 515);
        chk("pass_data", write_data_out, 5);
        drain();

        for (int i = 0; i < 20; i++) cyc(1, 0, 0, i + 1, 7, i % 16);
        cyc(0, 0, 0, 0, 0, 0);
        chk("bp_ready", ready_out, 0);
        chk("bp_ovf", overflow_out, 1);
        chk("bp_drop", drop_count_out, DC_EN ? 5 : 0);

        cyc(0, 1, 0, 0, 0, 0);
        w0 = n_writes;
        s0 = n_swaps;
        drain();
        chk("mark_writes", n_writes - w0, 15);
        chk("mark_swaps", n_swaps - s0, 1);

        cyc(1, 1, 1, 10, 20, 7);
        cyc(0, 0, 1, 0, 0, 0);
        chk("comb_we", write_enable_out, 1);
        chk("comb_swap0", swap_buffers_out, 0);
        chk("comb_addr", write_addr_out, 5130);
        cyc(0, 0, 1, 0, 0, 0);
        chk("comb_swap1", swap_buffers_out, 1);
        chk("comb_we0", write_enable_out, 0);
        drain();

        for (int i = 0; i < 1600; i++) begin
            cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 6,
                $urandom_range(0, 99) < (i < 800 ? 40 : 80),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 15)));
        end
        drain();

        for (int i = 0; i < 8; i++) cyc(1, 0, 0, i + 9, 3, i + 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", write_enable_out, 0);
        chk("mid_rst_addr", write_addr_out, 0);
        chk("mid_rst_data", write_data_out, 0);
        chk("mid_rst_swap", swap_buffers_out, 0);
        chk("mid_rst_ovf", overflow_out, 0);
        chk("mid_rst_drop", drop_count_out, 0);
        exp_q.delete();
        acc = 0;
        ret = 0;
        hs_pend = 0;
        exp_ovf = 1'b0;
        exp_drop = '0;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        w0 = n_writes;
        s0 = n_swaps;
        repeat (20) cyc(0, 0, 1, 0, 0, 0);
        chk("post_rst_writes", n_writes - w0, 0);
        chk("post_rst_swaps", n_swaps - s0, 0);
        chk("final_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pixel_write_fifo.md
PIXEL_WRITE_FIFO -- requirements
Module: pixel_write_fifo

Interface
REQ-001 SHALL have parameter H_BITS, default `H_BITS, hcount width.
REQ-002 SHALL have parameter V_BITS, default `V_BITS, vcount width.
REQ-003 SHALL have parameter DEPTH, default 16, entry count (power of 2, >=4).
REQ-004 SHALL have clk_in  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have rst_n_in  input  1  asynchronous, active-low reset.
REQ-006 SHALL have hcount_in  input  H_BITS  pixel column from the ray marcher.
REQ-007 SHALL have vcount_in  input  V_BITS  pixel row from the ray marcher.
REQ-008 SHALL have color_in  input  4  pixel color.
REQ-009 SHALL have valid_in  input  1  pixel present this cycle.
REQ-010 SHALL have new_frame_in  input  1  frame-complete pulse.
REQ-011 SHALL have write_ready_in  input  1  BRAM write port accepts this cycle.
REQ-012 SHALL have write_enable_out  output  1  BRAM write strobe.
REQ-013 SHALL have write_addr_out  output  H_BITS+V_BITS  BRAM address.
REQ-014 SHALL have write_data_out  output  4  BRAM write data.
REQ-015 SHALL have swap_buffers_out  output  1  one-cycle buffer-swap pulse.
REQ-016 SHALL have ready_out  output  1  high when a pixel push would be accepted.
REQ-017 SHALL have overflow_out  output  1  sticky: a pixel or marker was dropped.
REQ-018 SHALL have drop_count_out  output  16  dropped-pixel count (see Configuration).

Function
REQ-019 SHALL store entries {addr, color, pix, mark}; addr = (vcount_in << H_BITS) + hcount_in, computed at push.
REQ-020 SHALL push one entry per cycle when valid_in or new_frame_in is high; both high -> single entry, pix=1, mark=1.
REQ-021 SHALL accept pix-only pushes only when occupancy < DEPTH-1; the last slot is reserved for markers.
REQ-022 SHALL accept any push containing mark when occupancy < DEPTH; at occupancy = DEPTH, drop it and set overflow_out.
REQ-023 SHALL drop a pix-only push at occupancy >= DEPTH-1, set overflow_out, keep the FIFO unchanged.
REQ-024 SHALL set ready_out = (occupancy < DEPTH-1), combinational from registered occupancy.
REQ-025 SHALL use output FSM states IDLE, WRITE, SWAP, with all outputs registered.
REQ-026 IDLE: if non-empty, pop head; pix=1 -> WRITE, else mark=1 -> SWAP.
REQ-027 WRITE: write_enable_out=1 with head addr/data held until write_ready_in=1; then mark -> SWAP, else pop next -> WRITE, or IDLE if empty.
REQ-028 SWAP: swap_buffers_out=1 for exactly one cycle, ignoring write_ready_in; then pop next or IDLE.
REQ-029 SHALL order every pixel pushed before a marker to be written before that marker's swap pulse; a combined entry writes first, then swaps.
REQ-030 SHALL present a push into an empty IDLE FIFO on outputs the next cycle (latency 1); sustained throughput 1 pixel/cycle with write_ready_in=1.
REQ-031 SHALL wrap read/write pointers modulo DEPTH; occupancy tracked in log2(DEPTH)+1 bits.
REQ-032 SHALL handle simultaneous push and pop in one cycle, occupancy unchanged; the full test uses pre-pop occupancy.

Reset
REQ-033 SHALL, on rst_n_in low, asynchronously clear pointers and occupancy, enter IDLE, and drive write_enable_out=0, write_addr_out=0, write_data_out=0, swap_buffers_out=0, overflow_out=0, drop_count_out=0.
REQ-034 SHALL, on reset asserted mid-WRITE or mid-SWAP, discard all queued entries; no swap pulse is emitted after release.
REQ-035 SHALL drive ready_out=1 from the first cycle after rst_n_in rises.

Configuration
REQ-036 SHALL use macro PIXEL_WRITE_FIFO_DROP_COUNT_EN; when defined, drop_count_out increments on each dropped pixel, saturating at 16'hFFFF.
REQ-037 SHALL, without PIXEL_WRITE_FIFO_DROP_COUNT_EN, tie drop_count_out to 0 and synthesize no counter; overflow_out is unaffected.

Verification
REQ-038 Pass-through: H_BITS=8, write_ready_in=1, push (h=3, v=2, color=5) -> next cycle write_enable_out=1, addr=515, data=5.
REQ-039 Backpressure: write_ready_in=0, push 20 pixels, DEPTH=16 -> 15 accepted, ready_out=0, overflow_out=1, drop_count_out=5 with the macro or 0 without.
REQ-040 Marker reserve: occupancy 15 plus new_frame_in -> accepted; release write_ready_in -> 15 writes, then exactly one swap_buffers_out pulse.
REQ-041 Combined: valid_in and new_frame_in same cycle into empty FIFO -> write at N+1, swap pulse at N+2.
REQ-042 Reset mid-drain: 8 queued, rst_n_in low 1 cycle -> all outputs 0 immediately; no writes or swaps after release.
